sdram_job_arbiter: RTL

Shares the single sdram_control sweep engine between two independent job requesters, e.g. the memory tester and a readback/scrub client. Each job is one full-memory write or read sweep (start pulse … done pulse). The block holds off all grants until the engine's power-up init sweep completes, then grants round-robin. It muxes wdat, rnw and start into the engine and routes ready/done back to the owner. A watchdog flags sweeps that overrun.

---
 rtl/sdram_job_arbiter_if.sv | 48 ++++
 rtl/sdram_job_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/sdram_job_arbiter_if.sv
// Bundle between job clients / sweep engine (master side) and the job arbiter (slave side).
// Carries both client ports, the engine port and the arbiter status outputs.
interface sdram_job_arbiter_if #(
    parameter int unsigned DRAM_DATA_SIZE = 16
);
    logic                      req0;
    logic                      rnw0;
    logic [DRAM_DATA_SIZE-1:0] wdat0;
    logic                      ready0;
    logic                      done0;

    logic                      req1;
    logic                      rnw1;
    logic [DRAM_DATA_SIZE-1:0] wdat1;
    logic                      ready1;
    logic                      done1;

    logic [DRAM_DATA_SIZE-1:0] rdat;

    logic                      eng_start;
    logic                      eng_rnw;
    logic [DRAM_DATA_SIZE-1:0] eng_wdat;
    logic                      eng_ready;
    logic                      eng_done;
    logic [DRAM_DATA_SIZE-1:0] eng_rdat;

    logic                      owner;
    logic                      busy;
    logic                      init_done;
    logic                      wd_err;
    logic [7:0]                wd_errcnt;

    modport slave (
        input  req0, rnw0, wdat0, req1, rnw1, wdat1,
        input  eng_ready, eng_done, eng_rdat,
        output ready0, done0, ready1, done1, rdat,
        output eng_start, eng_rnw, eng_wdat,
        output owner, busy, init_done, wd_err, wd_errcnt
    );

    modport master (
        output req0, rnw0, wdat0, req1, rnw1, wdat1,
        output eng_ready, eng_done, eng_rdat,
        input  ready0, done0, ready1, done1, rdat,
        input  eng_start, eng_rnw, eng_wdat,
        input  owner, busy, init_done, wd_err, wd_errcnt
    );
endinterface

// File: rtl/sdram_job_arbiter.sv
// Round-robin arbiter sharing one SDRAM sweep engine between two job clients,
// gated on the engine's power-up init sweep, with a per-sweep overrun watchdog.
module sdram_job_arbiter #(
    parameter int unsigned DRAM_DATA_SIZE = 16,
    parameter int unsigned WD_W           = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    sdram_job_arbiter_if.slave bus_io
);

    typedef enum logic [2:0] {StInit, StIdle, StStart, StRun, StFin} state_e;

    localparam logic [WD_W-1:0] WdMax = '1;
    localparam logic [WD_W-1:0] WdPre = WdMax - 1'b1;

    state_e            state_q, state_d;
    logic [1:0]        pend_q, pend_d;
    logic [1:0]        prnw_q, prnw_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              rnw_q, rnw_d;
    logic              init_q, init_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              wd_err_q, wd_err_d;
    logic [7:0]        errcnt_q, errcnt_d;

    logic              grant;
    logic              grant_id;
    logic [1:0]        grant_vec;
    logic [1:0]        req_in;
    logic [1:0]        rnw_in;
    logic              busy;
    logic [DRAM_DATA_SIZE-1:0] wdat_sel;

    always_comb begin
        req_in   = {bus_io.req1, bus_io.req0};
        rnw_in   = {bus_io.rnw1, bus_io.rnw0};
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        rnw_d    = rnw_q;
        init_d   = init_q;
        wd_d     = wd_q;
        wd_err_d = 1'b0;
        errcnt_d = errcnt_q;
        grant    = 1'b0;
        // On a tie the client that did not own the engine last goes first.
        grant_id = (&pend_q) ? ~last_q : pend_q[1];

        unique case (state_q)
            StInit: begin
                if (bus_io.eng_done) begin
                    init_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (|pend_q) begin
                    grant   = 1'b1;
                    owner_d = grant_id;
                    rnw_d   = prnw_q[grant_id];
                    state_d = StStart;
                end
            end
            StStart: state_d = StRun;
            StRun: begin
                // Counter parks at all-ones so a stuck sweep reports only once.
                if (wd_q == WdPre) begin
                    wd_d     = WdMax;
                    wd_err_d = 1'b1;
                    if (errcnt_q != 8'hff) errcnt_d = errcnt_q + 8'd1;
                end else if (wd_q != WdMax) begin
                    wd_d = wd_q + 1'b1;
                end
                if (bus_io.eng_done) state_d = StFin;
            end
            StFin: begin
                last_d  = owner_q;
                wd_d    = '0;
                state_d = StIdle;
            end
            default: state_d = StInit;
        endcase

        grant_vec = {grant & grant_id, grant & ~grant_id};
        pend_d    = pend_q & ~grant_vec;
        prnw_d    = prnw_q;
        // A request landing on its own grant edge re-queues the job.
        for (int i = 0; i < 2; i++) begin
            if (req_in[i] && (!pend_q[i] || grant_vec[i])) begin
                pend_d[i] = 1'b1;
                prnw_d[i] = rnw_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StInit;
            pend_q   <= 2'b00;
            prnw_q   <= 2'b00;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            rnw_q    <= 1'b0;
            init_q   <= 1'b0;
            wd_q     <= '0;
            wd_err_q <= 1'b0;
            errcnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            prnw_q   <= prnw_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            rnw_q    <= rnw_d;
            init_q   <= init_d;
            wd_q     <= wd_d;
            wd_err_q <= wd_err_d;
            errcnt_q <= errcnt_d;
        end
    end

    always_comb begin
        busy     = (state_q == StStart) || (state_q == StRun) || (state_q == StFin);
        wdat_sel = owner_q ? bus_io.wdat1 : bus_io.wdat0;

        bus_io.busy      = busy;
        bus_io.owner     = owner_q;
        bus_io.init_done = init_q;
        bus_io.wd_err    = wd_err_q;
        bus_io.wd_errcnt = errcnt_q;
        bus_io.eng_start = (state_q == StStart);
        bus_io.eng_rnw   = rnw_q;
        bus_io.eng_wdat  = wdat_sel;
        bus_io.rdat      = bus_io.eng_rdat;
        bus_io.ready0    = bus_io.eng_ready & busy & ~owner_q;
        bus_io.ready1    = bus_io.eng_ready & busy & owner_q;
        bus_io.done0     = (state_q == StFin) & ~owner_q;
        bus_io.done1     = (state_q == StFin) & owner_q;
    end

endmodule
